// File: rtl/elevator_dispatcher_if.sv
// Dispatcher <-> request/motion-unit signal bundle. The master side supplies the buttons and
// the motion feedback; the slave side (the dispatcher) returns the direction, door and lamps.
interface elevator_dispatcher_if;
    logic [6:0] carRequest;
    logic [6:0] hallUp;
    logic [6:0] hallDown;
    logic [2:0] currentFloor;
    logic       move;
    logic [1:0] currentDirection;
    logic       doorState;
    logic [6:0] pendingCar;
    logic [6:0] pendingUp;
    logic [6:0] pendingDown;

    modport master (
        output carRequest, hallUp, hallDown, currentFloor, move,
        input  currentDirection, doorState, pendingCar, pendingUp, pendingDown
    );
    modport slave (
        input  carRequest, hallUp, hallDown, currentFloor, move,
        output currentDirection, doorState, pendingCar, pendingUp, pendingDown
    );
endinterface

// File: rtl/elevator_dispatcher.sv
// Collective-selective dispatcher for a 2-way, 7-floor car: latches calls, picks the sweep
// direction, times door openings and clears calls as they are served.
module elevator_dispatcher #(
    parameter logic [31:0] DOOR_HOLD = 32'd100_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    elevator_dispatcher_if.slave bus
);
    localparam logic [1:0] STOP = 2'b00, UP = 2'b10, DOWN = 2'b01;
    typedef enum logic [1:0] {IDLE, GO, RUN, DOOR_OPEN} state_t;

    state_t      state;
    logic        sweep_up, move_q;
    logic [31:0] cnt;

    logic [6:0] car_m, up_m, down_m, any_m, fmask, above_mask, below_mask, sw_hall, op_hall;
    logic       fvalid, above, below, here, ahead, behind, go_up;
    logic       car_here, sw_here, op_here, stop_here;
    logic       clr_c, clr_sw, clr_op, clr_u, clr_d;

    // Presses of this cycle join the decision so dir/door react one clk after the press.
    assign car_m  = bus.pendingCar  | bus.carRequest;
    assign up_m   = bus.pendingUp   | (bus.hallUp   & 7'b0111111);
    assign down_m = bus.pendingDown | (bus.hallDown & 7'b1111110);
    assign any_m  = car_m | up_m | down_m;

    assign fvalid     = (bus.currentFloor != 3'd0) && !bus.move;
    assign fmask      = fvalid ? (7'd1 << (bus.currentFloor - 3'd1)) : 7'd0;
    assign below_mask = fmask - 7'd1;
    assign above_mask = ~(fmask | below_mask);

    assign above     = |(any_m & above_mask);
    assign below     = |(any_m & below_mask);
    assign here      = |(any_m & fmask);
    assign ahead     = sweep_up ? above : below;
    assign behind    = sweep_up ? below : above;
    assign sw_hall   = sweep_up ? up_m : down_m;
    assign op_hall   = sweep_up ? down_m : up_m;
    assign car_here  = |(car_m & fmask);
    assign sw_here   = |(sw_hall & fmask);
    assign op_here   = |(op_hall & fmask);
    assign stop_here = car_here || sw_here || (op_here && !ahead);
    assign go_up     = above && (!below || sweep_up);

    // Opposite-direction hall call at the floor is only served on reversal.
    always_comb begin
        clr_c  = 1'b0;
        clr_sw = 1'b0;
        clr_op = 1'b0;
        if (fvalid) begin
            case (state)
                IDLE: if (here) begin
                    clr_c  = 1'b1;
                    clr_sw = 1'b1;
                    clr_op = 1'b1;
                end
                RUN: if (stop_here) begin
                    clr_c  = 1'b1;
                    clr_sw = 1'b1;
                end
                DOOR_OPEN: if (car_here || sw_here) begin
                    clr_c  = 1'b1;
                    clr_sw = 1'b1;
                end else if (cnt == 32'd0 && !ahead && op_here) begin
                    clr_op = 1'b1;
                end
                default: ;
            endcase
        end
    end
    assign clr_u = sweep_up ? clr_sw : clr_op;
    assign clr_d = sweep_up ? clr_op : clr_sw;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            sweep_up             <= 1'b1;
            move_q               <= 1'b0;
            cnt                  <= 32'd0;
            bus.currentDirection <= STOP;
            bus.doorState        <= 1'b0;
            bus.pendingCar       <= 7'd0;
            bus.pendingUp        <= 7'd0;
            bus.pendingDown      <= 7'd0;
        end else begin
            move_q          <= bus.move;
            bus.pendingCar  <= car_m  & ~(clr_c ? fmask : 7'd0);
            bus.pendingUp   <= up_m   & ~(clr_u ? fmask : 7'd0);
            bus.pendingDown <= down_m & ~(clr_d ? fmask : 7'd0);
            case (state)
                IDLE: begin
                    bus.currentDirection <= STOP;
                    bus.doorState        <= 1'b0;
                    if (fvalid && here) begin
                        state         <= DOOR_OPEN;
                        bus.doorState <= 1'b1;
                        cnt           <= DOOR_HOLD - 32'd1;
                    end else if (fvalid && (above || below)) begin
                        sweep_up             <= go_up;
                        state                <= GO;
                        bus.currentDirection <= go_up ? UP : DOWN;
                    end
                end
                GO: if (bus.move && !move_q) state <= RUN;
                RUN: if (fvalid) begin
                    if (stop_here) begin
                        state                <= DOOR_OPEN;
                        bus.doorState        <= 1'b1;
                        bus.currentDirection <= STOP;
                        cnt                  <= DOOR_HOLD - 32'd1;
                    end else if (!ahead) begin
                        // Only calls behind remain: let IDLE re-dispatch rather than overrun.
                        state                <= IDLE;
                        bus.currentDirection <= STOP;
                    end
                end
                DOOR_OPEN: if (fvalid) begin
                    if (car_here || sw_here) begin
                        cnt <= DOOR_HOLD - 32'd1;
                    end else if (cnt != 32'd0) begin
                        cnt <= cnt - 32'd1;
                    end else if (ahead) begin
                        bus.doorState        <= 1'b0;
                        state                <= GO;
                        bus.currentDirection <= sweep_up ? UP : DOWN;
                    end else if (op_here) begin
                        sweep_up <= ~sweep_up;
                        cnt      <= DOOR_HOLD - 32'd1;
                    end else if (behind) begin
                        sweep_up             <= ~sweep_up;
                        bus.doorState        <= 1'b0;
                        state                <= GO;
                        bus.currentDirection <= sweep_up ? DOWN : UP;
                    end else begin
                        bus.doorState <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_elevator_dispatcher.sv
// Bench for elevator_dispatcher: vector table, hand sequences for multi-cycle cases, and a
// random run with a behavioural motion unit checked against a floor-array reference model.
module tb_elevator_dispatcher;
    localparam int H = 4;
    localparam logic [1:0] UPV = 2'b10, DNV = 2'b01;
    localparam int WAITING = 0, DEPART = 1, TRAVEL = 2, DOORS = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    elevator_dispatcher_if bus();
    elevator_dispatcher #(.DOOR_HOLD(32'(H))) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [2:0] fl;
        logic [6:0] car, up, dn;
        logic [1:0] edir;
        logic       edoor;
        logic [6:0] epc, epu, epd;
    } vec_t;
    vec_t vt[9];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.carRequest = 7'd0;
        bus.hallUp = 7'd0;
        bus.hallDown = 7'd0;
        bus.move = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // One floor of travel: depart, then arrive at nf with move low.
    task automatic hop(input int nf);
        bus.move = 1'b1;
        step();
        bus.currentFloor = 3'(nf);
        bus.move = 1'b0;
        step();
    endtask

    task automatic door_cycles(input int already, output int n);
        n = already;
        for (int k = 0; k < 200 && bus.doorState; k++) begin
            step();
            if (bus.doorState) n++;
        end
        chk("door_closes", int'(bus.doorState), 0);
    endtask

    // Reference model: pending calls as per-floor arrays, behaviour from the dispatch rules.
    bit mpc[1:7], mpu[1:7], mpd[1:7], cc[1:7], cu[1:7], cd[1:7];
    int mmode, mtimer;
    bit mup, mprev, mdoor;
    logic [1:0] mdir;

    function automatic bit has(int lo, int hi);
        bit r = 1'b0;
        for (int i = 1; i <= 7; i++)
            if (i >= lo && i <= hi) r |= cc[i] | cu[i] | cd[i];
        return r;
    endfunction

    function automatic logic [6:0] packed_of(int sel);
        logic [6:0] r = 7'd0;
        for (int i = 1; i <= 7; i++)
            r[i-1] = (sel == 0) ? mpc[i] : (sel == 1) ? mpu[i] : mpd[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 1; i <= 7; i++) begin mpc[i] = 0; mpu[i] = 0; mpd[i] = 0; end
        mmode = WAITING; mtimer = 0; mup = 1; mprev = 0; mdoor = 0; mdir = 2'b00;
    endtask

    task automatic model_clock(input logic [6:0] car, input logic [6:0] up, input logic [6:0] dn,
                               input int fl, input bit mv);
        bit ok, ahd, bhd, same, opp, upward;
        bit clrc = 0, clru = 0, clrd = 0;
        for (int i = 1; i <= 7; i++) begin
            cc[i] = mpc[i] | car[i-1];
            cu[i] = mpu[i] | (up[i-1] && i != 7);
            cd[i] = mpd[i] | (dn[i-1] && i != 1);
        end
        ok = (fl >= 1 && fl <= 7) && !mv;
        ahd = 0; bhd = 0; same = 0; opp = 0;
        if (ok) begin
            ahd  = mup ? has(fl + 1, 7) : has(1, fl - 1);
            bhd  = mup ? has(1, fl - 1) : has(fl + 1, 7);
            same = mup ? cu[fl] : cd[fl];
            opp  = mup ? cd[fl] : cu[fl];
        end
        case (mmode)
            WAITING: begin
                mdir = 2'b00; mdoor = 0;
                if (ok && (cc[fl] | cu[fl] | cd[fl])) begin
                    clrc = 1; clru = 1; clrd = 1;
                    mmode = DOORS; mdoor = 1; mtimer = H - 1;
                end else if (ok && (ahd || bhd)) begin
                    upward = has(fl + 1, 7);
                    if (!(upward && has(1, fl - 1))) mup = upward;
                    mmode = DEPART; mdir = mup ? UPV : DNV;
                end
            end
            DEPART: if (mv && !mprev) mmode = TRAVEL;
            TRAVEL: if (ok) begin
                if (cc[fl] || same || (opp && !ahd)) begin
                    clrc = 1; if (mup) clru = 1; else clrd = 1;
                    mmode = DOORS; mdoor = 1; mdir = 2'b00; mtimer = H - 1;
                end else if (!ahd) begin
                    mmode = WAITING; mdir = 2'b00;
                end
            end
            default: if (ok) begin
                if (cc[fl] || same) begin
                    clrc = 1; if (mup) clru = 1; else clrd = 1;
                    mtimer = H - 1;
                end else if (mtimer > 0) begin
                    mtimer--;
                end else if (ahd) begin
                    mdoor = 0; mmode = DEPART; mdir = mup ? UPV : DNV;
                end else if (opp) begin
                    if (mup) clrd = 1; else clru = 1;
                    mup = !mup; mtimer = H - 1;
                end else if (bhd) begin
                    mup = !mup; mdoor = 0; mmode = DEPART; mdir = mup ? UPV : DNV;
                end else begin
                    mdoor = 0; mmode = WAITING;
                end
            end
        endcase
        for (int i = 1; i <= 7; i++) begin
            mpc[i] = cc[i] & !(clrc && i == fl);
            mpu[i] = cu[i] & !(clru && i == fl);
            mpd[i] = cd[i] & !(clrd && i == fl);
        end
        mprev = mv;
    endtask

    initial begin
        int n, mfl, hold, trav;
        bit mv, goup;
        logic [6:0] rc, ru, rd;

        vt[0] = '{3'd1, 7'b0010000, 7'b0000000, 7'b0000000, 2'b10, 1'b0, 7'b0010000, 7'b0000000, 7'b0000000};
        vt[1] = '{3'd2, 7'b0000000, 7'b0000010, 7'b0000000, 2'b00, 1'b1, 7'b0000000, 7'b0000000, 7'b0000000};
        vt[2] = '{3'd4, 7'b1000001, 7'b0000000, 7'b0000000, 2'b10, 1'b0, 7'b1000001, 7'b0000000, 7'b0000000};
        vt[3] = '{3'd7, 7'b0000000, 7'b1000000, 7'b0000001, 2'b00, 1'b0, 7'b0000000, 7'b0000000, 7'b0000000};
        vt[4] = '{3'd3, 7'b0000001, 7'b0000000, 7'b0000001, 2'b01, 1'b0, 7'b0000001, 7'b0000000, 7'b0000000};
        vt[5] = '{3'd0, 7'b0000100, 7'b0000000, 7'b0000000, 2'b00, 1'b0, 7'b0000100, 7'b0000000, 7'b0000000};
        vt[6] = '{3'd5, 7'b0010001, 7'b0010000, 7'b0010000, 2'b00, 1'b1, 7'b0000001, 7'b0000000, 7'b0000000};
        vt[7] = '{3'd7, 7'b0000000, 7'b0000000, 7'b1000000, 2'b00, 1'b1, 7'b0000000, 7'b0000000, 7'b0000000};
        vt[8] = '{3'd6, 7'b0000000, 7'b0000010, 7'b0000000, 2'b01, 1'b0, 7'b0000000, 7'b0000010, 7'b0000000};

        bus.currentFloor = 3'd1;
        do_reset();
        chk("reset_dir", int'(bus.currentDirection), 0);
        chk("reset_door", int'(bus.doorState), 0);
        chk("reset_pend", int'({bus.pendingCar, bus.pendingUp, bus.pendingDown}), 0);

        for (int v = 0; v < 9; v++) begin
            do_reset();
            bus.currentFloor = vt[v].fl;
            bus.carRequest = vt[v].car;
            bus.hallUp = vt[v].up;
            bus.hallDown = vt[v].dn;
            step();
            bus.carRequest = 7'd0; bus.hallUp = 7'd0; bus.hallDown = 7'd0;
            chk($sformatf("vec%0d_dir", v), int'(bus.currentDirection), int'(vt[v].edir));
            chk($sformatf("vec%0d_door", v), int'(bus.doorState), int'(vt[v].edoor));
            chk($sformatf("vec%0d_pc", v), int'(bus.pendingCar), int'(vt[v].epc));
            chk($sformatf("vec%0d_pu", v), int'(bus.pendingUp), int'(vt[v].epu));
            chk($sformatf("vec%0d_pd", v), int'(bus.pendingDown), int'(vt[v].epd));
        end

        // Car call to floor 5 from floor 1: UP until arrival at 5, then door.
        do_reset();
        bus.currentFloor = 3'd1;
        bus.carRequest = 7'b0010000;
        step();
        bus.carRequest = 7'd0;
        chk("t1_pc", int'(bus.pendingCar), int'(7'b0010000));
        chk("t1_dir", int'(bus.currentDirection), int'(UPV));
        for (int f = 2; f <= 4; f++) begin
            hop(f);
            chk($sformatf("t1_dir_at%0d", f), int'(bus.currentDirection), int'(UPV));
        end
        hop(5);
        chk("t1_stop_dir", int'(bus.currentDirection), 0);
        chk("t1_stop_door", int'(bus.doorState), 1);
        chk("t1_stop_pc", int'(bus.pendingCar), 0);

        // Pass floor 3 with a down call there, stop at 6, then reverse toward 3.
        do_reset();
        bus.currentFloor = 3'd1;
        bus.carRequest = 7'b0100000;
        bus.hallDown = 7'b0000100;
        step();
        bus.carRequest = 7'd0; bus.hallDown = 7'd0;
        hop(2);
        hop(3);
        chk("t2_dir_at3", int'(bus.currentDirection), int'(UPV));
        chk("t2_door_at3", int'(bus.doorState), 0);
        chk("t2_pd_at3", int'(bus.pendingDown), int'(7'b0000100));
        hop(4); hop(5); hop(6);
        chk("t3_door", int'(bus.doorState), 1);
        chk("t3_dir", int'(bus.currentDirection), 0);
        chk("t3_pc", int'(bus.pendingCar), 0);
        door_cycles(1, n);
        chk("t3_door_len", n, H);
        chk("t3_dir_after", int'(bus.currentDirection), int'(DNV));
        chk("t3_pd_after", int'(bus.pendingDown), int'(7'b0000100));

        // Hall up at the idle floor, re-pressed while open.
        do_reset();
        bus.currentFloor = 3'd2;
        bus.hallUp = 7'b0000010;
        step();
        bus.hallUp = 7'd0;
        chk("t4_door", int'(bus.doorState), 1);
        chk("t4_dir", int'(bus.currentDirection), 0);
        chk("t4_pu", int'(bus.pendingUp), 0);
        step();
        bus.hallUp = 7'b0000010;
        step();
        bus.hallUp = 7'd0;
        chk("t4_pu_repress", int'(bus.pendingUp), 0);
        door_cycles(3, n);
        chk("t4_door_len", n, H + 2);

        // Sweep DOWN retained in IDLE decides a two-sided request.
        do_reset();
        bus.currentFloor = 3'd5;
        bus.carRequest = 7'b0001000;
        step();
        bus.carRequest = 7'd0;
        chk("t5_dir_first", int'(bus.currentDirection), int'(DNV));
        hop(4);
        chk("t5_door", int'(bus.doorState), 1);
        door_cycles(1, n);
        chk("t5_idle_dir", int'(bus.currentDirection), 0);
        bus.carRequest = 7'b1000001;
        step();
        bus.carRequest = 7'd0;
        chk("t5_dir", int'(bus.currentDirection), int'(DNV));
        chk("t5_pc", int'(bus.pendingCar), int'(7'b1000001));

        // Reset while the door is open.
        do_reset();
        bus.currentFloor = 3'd2;
        bus.carRequest = 7'b0000010;
        step();
        bus.carRequest = 7'd0;
        chk("t6_door_open", int'(bus.doorState), 1);
        step();
        reset = 1'b1;
        bus.carRequest = 7'b0001000;
        step();
        reset = 1'b0;
        bus.carRequest = 7'd0;
        chk("t6_door", int'(bus.doorState), 0);
        chk("t6_dir", int'(bus.currentDirection), 0);
        chk("t6_pend", int'({bus.pendingCar, bus.pendingUp, bus.pendingDown}), 0);
        step();
        chk("t6_idle_dir", int'(bus.currentDirection), 0);
        bus.carRequest = 7'b0010000;
        step();
        bus.carRequest = 7'd0;
        chk("t6_idle_go", int'(bus.currentDirection), int'(UPV));

        // Random calls with a motion unit that follows the commanded direction.
        bus.currentFloor = 3'd1;
        do_reset();
        model_reset();
        mfl = 1; mv = 0; hold = 0; trav = 0; goup = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (mv) begin
                trav--;
                if (trav == 0) begin
                    mfl = goup ? mfl + 1 : mfl - 1;
                    mv = 0;
                    hold = $urandom_range(1, 3);
                end
            end else if (hold > 0) begin
                hold--;
            end else if (bus.currentDirection == UPV && mfl < 7) begin
                mv = 1; goup = 1; trav = $urandom_range(1, 3);
            end else if (bus.currentDirection == DNV && mfl > 1) begin
                mv = 1; goup = 0; trav = $urandom_range(1, 3);
            end
            rc = 7'd0; ru = 7'd0; rd = 7'd0;
            case ($urandom_range(0, 9))
                0: rc = 7'd1 << $urandom_range(0, 6);
                1: ru = 7'd1 << $urandom_range(0, 6);
                2: rd = 7'd1 << $urandom_range(0, 6);
                default: ;
            endcase
            bus.carRequest = rc; bus.hallUp = ru; bus.hallDown = rd;
            bus.currentFloor = 3'(mfl);
            bus.move = mv;
            model_clock(rc, ru, rd, mfl, mv);
            step();
            chk("rnd_dir", int'(bus.currentDirection), int'(mdir));
            chk("rnd_door", int'(bus.doorState), int'(mdoor));
            chk("rnd_pc", int'(bus.pendingCar), int'(packed_of(0)));
            chk("rnd_pu", int'(bus.pendingUp), int'(packed_of(1)));
            chk("rnd_pd", int'(bus.pendingDown), int'(packed_of(2)));
            if (bus.doorState) chk("rnd_door_stop", int'(bus.currentDirection), 0);
            if (mfl == 7) chk("rnd_no_up_at7", int'(bus.currentDirection == UPV), 0);
            if (mfl == 1) chk("rnd_no_dn_at1", int'(bus.currentDirection == DNV), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
